// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU codes and the ID/EX control bundle.
// Consumed by id_ex_reg and hazard_detect.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] alu_control;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_CAPTURE
    } stage_action_e;

    // An unknown (X) code falls to the default and is reported as not known.
    function automatic logic alu_code_known(input logic [2:0] code);
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds the
// instruction currently in ID.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_to_reg,
    input  logic [4:0] i_ex_rt,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    output logic       o_load_use
);

    logic w_rt_nonzero;
    logic w_src_match;

    assign w_rt_nonzero = (i_ex_rt != 5'd0);
    assign w_src_match  = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
    assign o_load_use   = i_ex_valid & i_ex_mem_to_reg & w_rt_nonzero
                        & i_id_valid & w_src_match;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall, illegal-op squashing and a
// saturating bubble counter. Load-use detection is built only when
// ID_EX_LOAD_USE_DETECT_EN is defined.
module id_ex_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [5:0]  op,
    input  logic        reg_write,
    input  logic        reg_dst,
    input  logic        alu_src,
    input  logic        branch,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic [2:0]  alu_control,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] sign_imm,
    input  logic [31:0] pc_plus4,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic        ex_illegal,
    output logic        ex_reg_write,
    output logic        ex_reg_dst,
    output logic        ex_alu_src,
    output logic        ex_branch,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic [2:0]  ex_alu_control,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_sign_imm,
    output logic [31:0] ex_pc_plus4,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic        load_use_stall,
    output logic [15:0] bubble_cnt
);

    logic          r_valid;
    logic          r_illegal;
    id_ex_ctrl_t   r_ctrl;
    logic [31:0]   r_rd1;
    logic [31:0]   r_rd2;
    logic [31:0]   r_sign_imm;
    logic [31:0]   r_pc_plus4;
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;
    logic [4:0]    r_rd;
    logic [15:0]   r_bubble_cnt;

    logic          w_illegal;
    logic          w_load_use;
    id_ex_ctrl_t   w_id_ctrl;
    id_ex_ctrl_t   w_cap_ctrl;
    stage_action_e w_action;

`ifdef ID_EX_LOAD_USE_DETECT_EN
    hazard_detect u_hazard_detect (
        .i_ex_valid      (r_valid),
        .i_ex_mem_to_reg (r_ctrl.mem_to_reg),
        .i_ex_rt         (r_rt),
        .i_id_valid      (id_valid),
        .i_id_rs         (rs),
        .i_id_rt         (rt),
        .o_load_use      (w_load_use)
    );
`else
    assign w_load_use = 1'b0;
`endif

    // Unknown opcodes and R-type with an unrecognised (or X) ALU code are illegal.
    always_comb begin
        w_illegal = 1'b0;
        case (op)
            OP_RTYPE:                     w_illegal = !alu_code_known(alu_control);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI: w_illegal = 1'b0;
            default:                      w_illegal = 1'b1;
        endcase
    end

    assign w_id_ctrl  = '{reg_write, reg_dst, alu_src, branch,
                          mem_write, mem_to_reg, alu_control};
    assign w_cap_ctrl = w_illegal ? CTRL_BUBBLE : w_id_ctrl;

    always_comb begin
        w_action = ACT_CAPTURE;
        if (flush)
            w_action = ACT_BUBBLE;
        else if (stall)
            w_action = ACT_HOLD;
        else if (w_load_use || !id_valid)
            w_action = ACT_BUBBLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_illegal    <= 1'b0;
            r_ctrl       <= CTRL_BUBBLE;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_sign_imm   <= '0;
            r_pc_plus4   <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_bubble_cnt <= '0;
        end else begin
            case (w_action)
                ACT_BUBBLE: begin
                    r_valid    <= 1'b0;
                    r_illegal  <= 1'b0;
                    r_ctrl     <= CTRL_BUBBLE;
                    r_rd1      <= '0;
                    r_rd2      <= '0;
                    r_sign_imm <= '0;
                    r_pc_plus4 <= '0;
                    r_rs       <= '0;
                    r_rt       <= '0;
                    r_rd       <= '0;
                    if (r_bubble_cnt != 16'hFFFF)
                        r_bubble_cnt <= r_bubble_cnt + 16'd1;
                end
                ACT_CAPTURE: begin
                    r_valid    <= 1'b1;
                    r_illegal  <= w_illegal;
                    r_ctrl     <= w_cap_ctrl;
                    r_rd1      <= rd1;
                    r_rd2      <= rd2;
                    r_sign_imm <= sign_imm;
                    r_pc_plus4 <= pc_plus4;
                    r_rs       <= rs;
                    r_rt       <= rt;
                    r_rd       <= rd;
                end
                default: ;
            endcase
        end
    end

    assign ex_valid       = r_valid;
    assign ex_illegal     = r_illegal;
    assign ex_reg_write   = r_ctrl.reg_write;
    assign ex_reg_dst     = r_ctrl.reg_dst;
    assign ex_alu_src     = r_ctrl.alu_src;
    assign ex_branch      = r_ctrl.branch;
    assign ex_mem_write   = r_ctrl.mem_write;
    assign ex_mem_to_reg  = r_ctrl.mem_to_reg;
    assign ex_alu_control = r_ctrl.alu_control;
    assign ex_rd1         = r_rd1;
    assign ex_rd2         = r_rd2;
    assign ex_sign_imm    = r_sign_imm;
    assign ex_pc_plus4    = r_pc_plus4;
    assign ex_rs          = r_rs;
    assign ex_rt          = r_rt;
    assign ex_rd          = r_rd;
    assign load_use_stall = w_load_use;
    assign bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized
// traffic against a behavioural model of the ID/EX stage.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg;
    logic [5:0]  op;
    logic [2:0]  alu_control;
    logic [31:0] rd1, rd2, sign_imm, pc_plus4;
    logic [4:0]  rs, rt, rd;
    logic        stall, flush;
    logic        ex_valid, ex_illegal, ex_reg_write, ex_reg_dst, ex_alu_src;
    logic        ex_branch, ex_mem_write, ex_mem_to_reg, load_use_stall;
    logic [2:0]  ex_alu_control;
    logic [31:0] ex_rd1, ex_rd2, ex_sign_imm, ex_pc_plus4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] bubble_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural picture of what the EX stage should currently hold.
    logic        m_valid, m_illegal;
    logic [8:0]  m_ctrl;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc;
    logic [4:0]  m_rs, m_rt, m_rd;
    int          m_cnt;

    id_ex_reg dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .op(op),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .branch(branch), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .alu_control(alu_control), .rd1(rd1), .rd2(rd2), .sign_imm(sign_imm),
        .pc_plus4(pc_plus4), .rs(rs), .rt(rt), .rd(rd), .stall(stall),
        .flush(flush), .ex_valid(ex_valid), .ex_illegal(ex_illegal),
        .ex_reg_write(ex_reg_write), .ex_reg_dst(ex_reg_dst),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_control(ex_alu_control), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_sign_imm(ex_sign_imm), .ex_pc_plus4(ex_pc_plus4), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .load_use_stall(load_use_stall),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_valid = 1'b0; m_illegal = 1'b0; m_ctrl = '0;
        m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_cnt = 0;
    endfunction

    function automatic logic model_lu();
`ifdef ID_EX_LOAD_USE_DETECT_EN
        return m_valid && m_ctrl[3] && (m_rt != 5'd0) && id_valid === 1'b1
            && (m_rt == rs || m_rt == rt);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_bubble();
        m_valid = 1'b0; m_illegal = 1'b0; m_ctrl = '0;
        m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
    endfunction

    function automatic void model_edge();
        logic legal;
        if (flush) begin
            model_bubble();
        end else if (stall) begin
            // stage frozen
        end else if (model_lu() || !id_valid) begin
            model_bubble();
        end else begin
            legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000100)
                 || (op == 6'b001000)
                 || (op == 6'b000000 && !$isunknown(alu_control)
                     && (alu_control == 3'b000 || alu_control == 3'b001 ||
                         alu_control == 3'b010 || alu_control == 3'b110 ||
                         alu_control == 3'b111));
            m_valid   = 1'b1;
            m_illegal = !legal;
            m_ctrl    = legal ? {reg_write, reg_dst, alu_src, branch, mem_write,
                                 mem_to_reg, alu_control} : 9'd0;
            m_rd1 = rd1; m_rd2 = rd2; m_imm = sign_imm; m_pc = pc_plus4;
            m_rs = rs; m_rt = rt; m_rd = rd;
        end
    endfunction

    function automatic logic [170:0] model_vec();
        return {m_valid, m_illegal, m_ctrl, m_rd1, m_rd2, m_imm, m_pc,
                m_rs, m_rt, m_rd, model_lu(), m_cnt[15:0]};
    endfunction

    function automatic logic [170:0] dut_vec();
        return {ex_valid, ex_illegal, ex_reg_write, ex_reg_dst, ex_alu_src,
                ex_branch, ex_mem_write, ex_mem_to_reg, ex_alu_control,
                ex_rd1, ex_rd2, ex_sign_imm, ex_pc_plus4, ex_rs, ex_rt, ex_rd,
                load_use_stall, bubble_cnt};
    endfunction

    // Advance one clock edge, updating the model from the inputs seen at it.
    task automatic applyStimulus();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [8:0] c,
                             input logic [4:0] s, input logic [4:0] t,
                             input logic [4:0] d);
        id_valid = 1'b1; op = o;
        {reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, alu_control} = c;
        rs = s; rt = t; rd = d;
        rd1 = $urandom; rd2 = $urandom; sign_imm = $urandom; pc_plus4 = $urandom;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; stall = 1'b0;
        set_instr(6'b100011, 9'b101001_010, 5'd1, 5'd2, 5'd3);
        model_reset();
        #1;
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset_state got=%h exp=%h", dut_vec(), model_vec());
        end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_capture();
        set_instr(6'b100011, 9'b101001_010, 5'd3, 5'd8, 5'd0);
        rd1 = 32'h100; sign_imm = 32'd4;
        applyStimulus();
        vectors++;
        if ({ex_valid, ex_mem_to_reg, ex_alu_src, ex_alu_control, ex_rt}
            !== {1'b1, 1'b1, 1'b1, 3'b010, 5'd8}) begin
            miscompares++;
            $display("[TB] FAIL lw_capture got=%b%b%b_%b_%0d exp=111_010_8",
                     ex_valid, ex_mem_to_reg, ex_alu_src, ex_alu_control, ex_rt);
        end
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("[TB] FAIL lw_capture_all got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_illegal();
        set_instr(6'b111111, 9'd0, 5'd4, 5'd5, 5'd6);
        {reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg} = 6'bxxxxxx;
        alu_control = 3'bxxx;
        applyStimulus();
        vectors++;
        if (dut_vec() !== model_vec() || $isunknown(dut_vec())) begin
            miscompares++;
            $display("[TB] FAIL illegal_op got=%h exp=%h", dut_vec(), model_vec());
        end
        set_instr(6'b000000, 9'b110000_000, 5'd7, 5'd9, 5'd10);
        alu_control = 3'bxxx;
        applyStimulus();
        vectors++;
        if (dut_vec() !== model_vec() || $isunknown(dut_vec())) begin
            miscompares++;
            $display("[TB] FAIL rtype_unknown_funct got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(6'b100011, 9'b101001_010, 5'd3, 5'd8, 5'd0);
        applyStimulus();
        set_instr(6'b000000, 9'b110000_010, 5'd8, 5'd9, 5'd10);
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL load_use_step%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            applyStimulus();
        end
    endtask

    task automatic test_priority();
        set_instr(6'b101011, 9'b001010_010, 5'd2, 5'd3, 5'd0);
        flush = 1'b1; stall = 1'b1;
        applyStimulus();
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("[TB] FAIL flush_over_stall got=%h exp=%h", dut_vec(), model_vec());
        end
        flush = 1'b0;
        applyStimulus();
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("[TB] FAIL stall_holds_bubble got=%h exp=%h", dut_vec(), model_vec());
        end
        stall = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b001000, 6'b111111, 6'b010101};
        for (int n = 0; n < 400; n++) begin
            set_instr(ops[$urandom_range(0, 6)], 9'($urandom),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom));
            id_valid = ($urandom_range(0, 5) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            applyStimulus();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL random_%0d got=%h exp=%h", n, dut_vec(), model_vec());
            end
        end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_async_reset();
        set_instr(6'b001000, 9'b101000_010, 5'd1, 5'd2, 5'd0);
        stall = 1'b0; flush = 1'b0;
        applyStimulus();
        stall = 1'b1;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (dut_vec() !== model_vec() || ex_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got=%h exp=%h", dut_vec(), model_vec());
        end
        reset_n = 1'b1;
        stall = 1'b0; id_valid = 1'b0;
        applyStimulus();
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("[TB] FAIL after_reset_edge got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        id_valid = 1'b0;
        repeat (65534) applyStimulus();
        vectors++;
        if (bubble_cnt !== 16'd65534 || dut_vec() !== model_vec()) begin
            miscompares++;
            $display("[TB] FAIL preload_count got=%0d exp=65534", bubble_cnt);
        end
        flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            vectors++;
            if (bubble_cnt !== 16'hFFFF || dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL saturate_%0d got=%h exp=ffff", k, bubble_cnt);
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_illegal();
        test_load_use();
        test_priority();
        test_random();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
